// File: rtl/alu_mdu.sv
// Single-cycle ALU plus an iterative multiply/divide unit.
// The sequencer does one shift-add or restoring-divide step per cycle and writes the HI/LO pair.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   Op_A,
  input  logic [WIDTH-1:0]   Op_B,
  input  logic [4:0]         ALUctrl,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Start,
  output logic [WIDTH-1:0]   Alu_Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_AND  = 5'b00000,
    OP_OR   = 5'b00001,
    OP_ADD  = 5'b00010,
    OP_XOR  = 5'b00011,
    OP_SLL  = 5'b00100,
    OP_SUB  = 5'b00110,
    OP_SLT  = 5'b00111,
    OP_SRL  = 5'b01000,
    OP_SRA  = 5'b01001,
    OP_LUI  = 5'b01010,
    OP_SLTU = 5'b01011,
    OP_NOR  = 5'b01100,
    OP_SLLV = 5'b01101,
    OP_MFHI = 5'b01110,
    OP_MFLO = 5'b01111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] sum, diff;

  assign sum  = Op_A + Op_B;
  assign diff = Op_A - Op_B;
  assign Zero = (Op_A == Op_B);

  always_comb begin
    Alu_Result = '0;
    Overflow   = 1'b0;
    case (ALUctrl)
      OP_AND:  Alu_Result = Op_A & Op_B;
      OP_OR:   Alu_Result = Op_A | Op_B;
      OP_XOR:  Alu_Result = Op_A ^ Op_B;
      OP_NOR:  Alu_Result = ~(Op_A | Op_B);
      OP_ADD: begin
        Alu_Result = sum;
        Overflow   = (Op_A[WIDTH-1] == Op_B[WIDTH-1]) && (sum[WIDTH-1] != Op_A[WIDTH-1]);
      end
      OP_SUB: begin
        Alu_Result = diff;
        Overflow   = (Op_A[WIDTH-1] != Op_B[WIDTH-1]) && (diff[WIDTH-1] != Op_A[WIDTH-1]);
      end
      OP_SLT:  Alu_Result = {{(WIDTH-1){1'b0}}, $signed(Op_A) < $signed(Op_B)};
      OP_SLTU: Alu_Result = {{(WIDTH-1){1'b0}}, Op_A < Op_B};
      OP_SLL:  Alu_Result = Op_B << Shamt;
      OP_SRL:  Alu_Result = Op_B >> Shamt;
      OP_SRA:  Alu_Result = $unsigned($signed(Op_B) >>> Shamt);
      OP_SLLV: Alu_Result = Op_B << Op_A[SHAMT_W-1:0];
      OP_LUI:  Alu_Result = Op_B << (WIDTH / 2);
      OP_MFHI: Alu_Result = Hi;
      OP_MFLO: Alu_Result = Lo;
      default: Alu_Result = '0;
    endcase
  end

  // ---------------- mul/div sequencer ----------------
  state_e             state, state_nx;
  logic               load;
  logic               start_ok;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   work_hi, work_lo, mcand;
  logic               is_div, neg_hi, neg_lo;

  assign start_ok = Start && (ALUctrl[4:2] == 3'b100);
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign Busy     = (state == S_RUN);
  assign Done     = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE: if (start_ok) begin
        state_nx = S_RUN;
        load     = 1'b1;
      end
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: if (start_ok) begin
        state_nx = S_RUN;
        load     = 1'b1;
      end else begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand magnitudes and result-sign flags captured at launch
  logic               signed_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_op = ~ALUctrl[0];
  assign a_neg     = signed_op & Op_A[WIDTH-1];
  assign b_neg     = signed_op & Op_B[WIDTH-1];
  assign b_zero    = (Op_B == '0);
  assign mag_a     = a_neg ? -Op_A : Op_A;
  assign mag_b     = b_neg ? -Op_B : Op_B;

  // One iteration: work_hi is the product accumulator or partial remainder,
  // work_lo is the multiplier being consumed or the dividend turning into the quotient.
  logic [WIDTH:0]     madd, dtrial;
  logic [WIDTH-1:0]   step_hi, step_lo;

  always_comb begin
    madd   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
    dtrial = {work_hi, work_lo[WIDTH-1]} - {1'b0, mcand};
    if (is_div) begin
      if (!dtrial[WIDTH]) begin
        step_hi = dtrial[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {madd, work_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign prod_neg = -{step_hi, step_lo};

  always_comb begin
    if (is_div) begin
      fin_hi = neg_hi ? -step_hi : step_hi;
      fin_lo = neg_lo ? -step_lo : step_lo;
    end else begin
      {fin_hi, fin_lo} = neg_hi ? prod_neg : {step_hi, step_lo};
    end
  end

  // A zero divisor naturally yields quotient all-ones and remainder = |dividend|;
  // suppressing the quotient negation keeps Lo all-ones for signed DIV too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      mcand   <= '0;
      is_div  <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else if (load) begin
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= mag_a;
      mcand   <= mag_b;
      is_div  <= ALUctrl[1];
      neg_hi  <= ALUctrl[1] ? a_neg : (a_neg ^ b_neg);
      neg_lo  <= (a_neg ^ b_neg) & ~(ALUctrl[1] & b_zero);
    end else if (state == S_RUN) begin
      cnt     <= cnt + CNT_W'(1);
      work_hi <= step_hi;
      work_lo <= step_lo;
      if (last) begin
        Hi <= fin_hi;
        Lo <= fin_lo;
      end
    end
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised ALU with an attached iterative multiply/divide unit. The combinational path executes the single-cycle integer ops for the datapath execute stage in the same cycle. A start/busy/done sequencer runs signed and unsigned multiply and divide over WIDTH cycles and writes the HI/LO register pair, which the datapath reads back with MFHI/MFLO.

## Interface
- WIDTH, 32: operand/result width; must be even and ≥ 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op_A  in  WIDTH  first operand (rs); signed where the op is signed.
- Op_B  in  WIDTH  second operand (rt or immediate).
- ALUctrl  in  5  operation select.
- Shamt  in  SHAMT_W  constant shift amount (instruction shamt field).
- Start  in  1  launches the mul/div op on ALUctrl; sampled on clk.
- Alu_Result  out  WIDTH  combinational result.
- Zero  out  1  combinational; 1 when Op_A == Op_B.
- Overflow  out  1  combinational; signed overflow on ADD/SUB, else 0.
- Busy  out  1  registered; mul/div in progress.
- Done  out  1  registered; one-cycle pulse when Hi/Lo update.
- Hi  out  WIDTH  registered HI (product upper half / remainder).
- Lo  out  WIDTH  registered LO (product lower half / quotient).

## Operation
- ALUctrl codes: 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 SLL, 00110 SUB, 00111 SLT (signed), 01000 SRL, 01001 SRA, 01010 LUI, 01011 SLTU, 01100 NOR, 01101 SLLV, 01110 MFHI, 01111 MFLO, 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU.
- SLL/SRL/SRA shift Op_B by Shamt. SLLV shifts Op_B left by Op_A[SHAMT_W-1:0]. LUI = Op_B << (WIDTH/2).
- SLT and SLTU produce a result of 0 or 1, zero-extended to WIDTH.
- MFHI/MFLO return the current Hi/Lo. While Busy they return the pre-operation value.
- Mul/div codes and undefined codes: Alu_Result = 0, Overflow = 0. No simulation messages.
- ADD/SUB wrap modulo 2^WIDTH. Overflow = 1 when the operand signs make the signed result unrepresentable.
- Sequencer FSM, states IDLE, RUN, DONE:
  - IDLE→RUN: Start=1 and ALUctrl in 100xx. Operands and op are latched and a bit counter is cleared.
  - In RUN, Op_A, Op_B and ALUctrl are don't-care.
  - RUN: one bit per cycle (shift-add multiply, restoring divide on magnitudes). RUN→DONE after WIDTH cycles.
  - DONE: Hi/Lo already hold the result; Done=1.
  - DONE→IDLE if Start is low or carries a non-mul/div code.
  - DONE→RUN if Start=1 with a mul/div code (back-to-back accepted).
  - Start with a non-mul/div code in IDLE is ignored. Start in RUN is ignored and is not queued.
- Signed ops: operate on magnitudes, then negate the results.
  - Product sign = sign(A) xor sign(B).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU): Lo = all ones, Hi = dividend. Same latency.
- DIV MIN / −1: Lo = MIN, Hi = 0.

## Timing
- Reset (async, any state): FSM→IDLE; Busy=0, Done=0, Hi=0, Lo=0; counter cleared. An in-flight op is discarded and Hi/Lo are not partially updated.
- Start sampled at edge E0:
  - Busy=1 from after E0 through the cycle ending at edge E(WIDTH).
  - After E(WIDTH): Hi/Lo hold the new values, Done=1, Busy=0 for exactly one cycle.
  - Total latency is WIDTH+1 edges from the Start sample to the end of the Done cycle.
- Hi/Lo change only at the edge entering DONE (or at reset).
- Combinational outputs (Alu_Result, Zero, Overflow) settle within the cycle. They have no reset value and follow the inputs.

## Test plan
- Reset mid-RUN (assert rst at cycle 10 of a MULTU) -> Busy=0, Done=0, Hi=Lo=0 immediately; after release, Start accepted normally.
- ADD 0x7FFFFFFF+0x00000001 -> Alu_Result=0x80000000, Overflow=1. SUB 5−5 -> Alu_Result=0, Zero=1. SRA 0x80000000 by Shamt=4 -> 0xF8000000. LUI Op_B=0x1234 -> 0x12340000.
- MULT −3×5 with Start at E0 -> Busy 1 for 32 cycles, Done at cycle 33, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×2 -> Hi=1, Lo=0xFFFFFFFE.
- DIV −7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/0 -> Lo=0xFFFFFFFF, Hi=7. DIV 0x80000000/−1 -> Lo=0x80000000, Hi=0.
- Start pulse at RUN cycle 5 with different operands -> ignored; the original result is delivered at the original Done cycle. Start during the Done cycle -> Busy next cycle, second result after a further 32 cycles. MFLO during Busy returns the old Lo.
- WIDTH=16 instance: MULT 0x7FFF×0x7FFF -> Hi=0x3FFF, Lo=0x0001, Done at cycle 17.
